// File: rtl/terminal_arbiter.sv
// Two-terminal (matrix, LEDs) round-robin arbiter with a per-user
// function permission table, hold limit and denial reporting.
module terminal_arbiter #(
  parameter int N_IS     = 2,
  parameter int HOLD_MAX = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [N_IS-1:0]   REQ,
  input  logic [3*N_IS-1:0] USER,
  input  logic [3*N_IS-1:0] FUNC,
  input  logic [N_IS-1:0]   TERM,
  input  logic              PERM_WE,
  input  logic [2:0]        PERM_ADDR,
  input  logic [6:0]        PERM_DATA,
  output logic [N_IS-1:0]   GNT,
  output logic [N_IS-1:0]   DENY,
  output logic              MAT_VALID,
  output logic [2:0]        MAT_CODE,
  output logic              LED_VALID,
  output logic [2:0]        LED_CODE
);

  localparam int IW = (N_IS > 1) ? $clog2(N_IS) : 1;

  typedef enum logic [1:0] {
    IS_IDLE,
    IS_WAIT,
    IS_ACTIVE,
    IS_BLOCKED
  } is_state_t;

  typedef enum logic {
    T_FREE,
    T_BUSY
  } t_state_t;

  is_state_t       is_q   [N_IS];
  is_state_t       is_d   [N_IS];
  logic [N_IS-1:0] deny_q, deny_d;
  logic [6:0]      perm_tbl [8];

  t_state_t        t_q    [2];
  t_state_t        t_d    [2];
  logic [IW-1:0]   own_q  [2];
  logic [IW-1:0]   own_d  [2];
  logic [IW-1:0]   ptr_q  [2];
  logic [IW-1:0]   ptr_d  [2];
  logic [7:0]      cnt_q  [2];
  logic [7:0]      cnt_d  [2];
  logic [2:0]      code_q [2];
  logic [2:0]      code_d [2];

  logic [N_IS-1:0] perm;
  logic [N_IS-1:0] elig [2];
  logic            found [2];
  logic [IW-1:0]   pick  [2];
  logic [IW-1:0]   idx;

  // Lookup reads the registered table, so a same-cycle write is not seen.
  always_comb begin
    perm = '0;
    for (int i = 0; i < N_IS; i++)
      perm[i] = (FUNC[3*i +: 3] != 3'd0) &&
                perm_tbl[USER[3*i +: 3]][FUNC[3*i +: 3] - 3'd1];
  end

  always_comb begin
    for (int t = 0; t < 2; t++) begin
      elig[t] = '0;
      for (int i = 0; i < N_IS; i++)
        elig[t][i] = (is_q[i] == IS_WAIT) && REQ[i] &&
                     perm[i] && (TERM[i] == t[0]);
    end
  end

  always_comb begin
    idx = '0;
    for (int t = 0; t < 2; t++) begin
      found[t] = 1'b0;
      pick[t]  = '0;
      for (int k = 0; k < N_IS; k++) begin
        idx = IW'((int'(ptr_q[t]) + k) % N_IS);
        if (!found[t] && elig[t][idx]) begin
          found[t] = 1'b1;
          pick[t]  = idx;
        end
      end
    end
  end

  always_comb begin
    is_d   = is_q;
    deny_d = '0;
    t_d    = t_q;
    own_d  = own_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    code_d = code_q;

    for (int i = 0; i < N_IS; i++) begin
      unique case (is_q[i])
        IS_IDLE:
          if (REQ[i]) begin
            if (perm[i]) begin
              is_d[i] = IS_WAIT;
            end else begin
              is_d[i]   = IS_BLOCKED;
              deny_d[i] = 1'b1;
            end
          end
        IS_WAIT:
          if (!REQ[i]) begin
            is_d[i] = IS_IDLE;
          end else if (!perm[i]) begin
            is_d[i]   = IS_BLOCKED;
            deny_d[i] = 1'b1;
          end
        IS_ACTIVE: ;
        IS_BLOCKED:
          if (!REQ[i]) is_d[i] = IS_IDLE;
      endcase
    end

    // Terminal updates override the interface view for owners/grantees.
    for (int t = 0; t < 2; t++) begin
      unique case (t_q[t])
        T_FREE:
          if (found[t]) begin
            t_d[t]        = T_BUSY;
            own_d[t]      = pick[t];
            cnt_d[t]      = 8'd1;
            ptr_d[t]      = IW'((int'(pick[t]) + 1) % N_IS);
            is_d[pick[t]] = IS_ACTIVE;
            for (int i = 0; i < N_IS; i++)
              if (IW'(i) == pick[t])
                code_d[t] = FUNC[3*i +: 3];
          end
        T_BUSY: begin
          if (!REQ[own_q[t]] ||
              cnt_q[t] == 8'(HOLD_MAX)) begin
            t_d[t]    = T_FREE;
            cnt_d[t]  = 8'd0;
            code_d[t] = 3'd0;
            is_d[own_q[t]] = REQ[own_q[t]] ?
                             IS_BLOCKED : IS_IDLE;
          end else begin
            cnt_d[t] = cnt_q[t] + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < N_IS; i++)
        is_q[i] <= IS_IDLE;
      deny_q <= '0;
      for (int e = 0; e < 8; e++)
        perm_tbl[e] <= 7'd0;
      for (int t = 0; t < 2; t++) begin
        t_q[t]    <= T_FREE;
        own_q[t]  <= '0;
        ptr_q[t]  <= '0;
        cnt_q[t]  <= 8'd0;
        code_q[t] <= 3'd0;
      end
    end else begin
      is_q   <= is_d;
      deny_q <= deny_d;
      t_q    <= t_d;
      own_q  <= own_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      code_q <= code_d;
      if (PERM_WE)
        perm_tbl[PERM_ADDR] <= PERM_DATA;
    end
  end

  always_comb begin
    GNT = '0;
    for (int i = 0; i < N_IS; i++)
      GNT[i] = (is_q[i] == IS_ACTIVE);
  end

  assign DENY      = deny_q;
  assign MAT_VALID = (t_q[0] == T_BUSY);
  assign MAT_CODE  = MAT_VALID ? code_q[0] : 3'd0;
  assign LED_VALID = (t_q[1] == T_BUSY);
  assign LED_CODE  = LED_VALID ? code_q[1] : 3'd0;

endmodule

// File: tb/tb_terminal_arbiter.sv
// Directed bench for terminal_arbiter: grants, denials, round-robin,
// hold limit, independent terminals and mid-grant reset.
module tb_terminal_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req = '0;
  logic [5:0] user = '0;
  logic [5:0] func = '0;
  logic [1:0] term = '0;
  logic       perm_we = 1'b0;
  logic [2:0] perm_addr = '0;
  logic [6:0] perm_data = '0;
  logic [1:0] gnt, deny;
  logic       mat_valid, led_valid;
  logic [2:0] mat_code, led_code;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] e;

  always #5 clk = ~clk;

  terminal_arbiter #(.N_IS(2), .HOLD_MAX(4)) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .REQ(req),
    .USER(user),
    .FUNC(func),
    .TERM(term),
    .PERM_WE(perm_we),
    .PERM_ADDR(perm_addr),
    .PERM_DATA(perm_data),
    .GNT(gnt),
    .DENY(deny),
    .MAT_VALID(mat_valid),
    .MAT_CODE(mat_code),
    .LED_VALID(led_valid),
    .LED_CODE(led_code)
  );

  wire [11:0] obs = {gnt, deny, mat_valid, mat_code,
                     led_valid, led_code};

  function automatic logic [11:0] pk(
    input logic [1:0] g, input logic [1:0] d,
    input logic mv, input logic [2:0] mc,
    input logic lv, input logic [2:0] lc);
    return {g, d, mv, mc, lv, lc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [6:0] d);
    perm_we = 1'b1;
    perm_addr = a;
    perm_data = d;
    tick();
    perm_we = 1'b0;
  endtask

  task automatic set_is(input int i, input logic [2:0] u,
                        input logic [2:0] f, input logic t);
    user[3*i +: 3] = u;
    func[3*i +: 3] = f;
    term[i] = t;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    e = '0; n_checks++;
    if (obs !== e) begin
      $display("FAIL reset_async obs=%h exp=%h", obs, e); n_fail++;
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs !== e) begin
      $display("FAIL reset_idle obs=%h exp=%h", obs, e); n_fail++;
    end
  endtask

  task automatic test_grant();
    wr(3'd5, 7'h7F);
    set_is(0, 3'd5, 3'd3, 1'b0);
    req = 2'b01;
    tick();
    e = '0; n_checks++;
    if (obs !== e) begin
      $display("FAIL grant_wait obs=%h exp=%h", obs, e); n_fail++;
    end
    tick();
    e = pk(2'b01, 2'b00, 1'b1, 3'd3, 1'b0, 3'd0); n_checks++;
    if (obs !== e) begin
      $display("FAIL grant_on obs=%h exp=%h", obs, e); n_fail++;
    end
    func[2:0] = 3'd5;
    tick();
    n_checks++;
    if (obs !== e) begin
      $display("FAIL code_latched obs=%h exp=%h", obs, e); n_fail++;
    end
    req = 2'b00;
    tick();
    e = '0; n_checks++;
    if (obs !== e) begin
      $display("FAIL grant_release obs=%h exp=%h", obs, e); n_fail++;
    end
  endtask

  task automatic test_deny();
    wr(3'd2, 7'h00);
    set_is(1, 3'd2, 3'd4, 1'b0);
    req = 2'b10;
    tick();
    e = pk(2'b00, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0); n_checks++;
    if (obs !== e) begin
      $display("FAIL deny_pulse obs=%h exp=%h", obs, e); n_fail++;
    end
    tick();
    e = '0; n_checks++;
    if (obs !== e) begin
      $display("FAIL deny_once obs=%h exp=%h", obs, e); n_fail++;
    end
    wr(3'd2, 7'h08);
    tick();
    n_checks++;
    if (obs !== e) begin
      $display("FAIL deny_hold obs=%h exp=%h", obs, e); n_fail++;
    end
    req = 2'b00;
    tick();
    req = 2'b10;
    tick();
    n_checks++;
    if (obs !== e) begin
      $display("FAIL rereq_wait obs=%h exp=%h", obs, e); n_fail++;
    end
    tick();
    e = pk(2'b10, 2'b00, 1'b1, 3'd4, 1'b0, 3'd0); n_checks++;
    if (obs !== e) begin
      $display("FAIL rereq_grant obs=%h exp=%h", obs, e); n_fail++;
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    set_is(0, 3'd5, 3'd3, 1'b1);
    set_is(1, 3'd2, 3'd4, 1'b1);
    req = 2'b11;
    tick(); tick();
    e = pk(2'b01, 2'b00, 1'b0, 3'd0, 1'b1, 3'd3); n_checks++;
    if (obs !== e) begin
      $display("FAIL rr_first obs=%h exp=%h", obs, e); n_fail++;
    end
    tick();
    n_checks++;
    if (obs !== e) begin
      $display("FAIL rr_hold obs=%h exp=%h", obs, e); n_fail++;
    end
    req = 2'b10;
    tick();
    e = '0; n_checks++;
    if (obs !== e) begin
      $display("FAIL rr_free obs=%h exp=%h", obs, e); n_fail++;
    end
    tick();
    e = pk(2'b10, 2'b00, 1'b0, 3'd0, 1'b1, 3'd4); n_checks++;
    if (obs !== e) begin
      $display("FAIL rr_second obs=%h exp=%h", obs, e); n_fail++;
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_hold();
    set_is(0, 3'd5, 3'd3, 1'b0);
    req = 2'b01;
    tick();
    e = pk(2'b01, 2'b00, 1'b1, 3'd3, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (obs !== e) begin
        $display("FAIL hold_on[%0d] obs=%h exp=%h", k, obs, e);
        n_fail++;
      end
    end
    e = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (obs !== e) begin
        $display("FAIL hold_forced[%0d] obs=%h exp=%h", k, obs, e);
        n_fail++;
      end
    end
    req = 2'b00;
    tick();
    req = 2'b01;
    tick(); tick();
    e = pk(2'b01, 2'b00, 1'b1, 3'd3, 1'b0, 3'd0); n_checks++;
    if (obs !== e) begin
      $display("FAIL hold_regrant obs=%h exp=%h", obs, e); n_fail++;
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_independent();
    set_is(0, 3'd5, 3'd3, 1'b0);
    set_is(1, 3'd2, 3'd4, 1'b1);
    req = 2'b11;
    tick(); tick();
    e = pk(2'b11, 2'b00, 1'b1, 3'd3, 1'b1, 3'd4); n_checks++;
    if (obs !== e) begin
      $display("FAIL indep_both obs=%h exp=%h", obs, e); n_fail++;
    end
    req = 2'b00;
    tick();
    e = '0; n_checks++;
    if (obs !== e) begin
      $display("FAIL indep_release obs=%h exp=%h", obs, e); n_fail++;
    end
  endtask

  task automatic test_reset_mid();
    set_is(0, 3'd5, 3'd3, 1'b0);
    req = 2'b01;
    tick(); tick();
    e = pk(2'b01, 2'b00, 1'b1, 3'd3, 1'b0, 3'd0); n_checks++;
    if (obs !== e) begin
      $display("FAIL mid_pre obs=%h exp=%h", obs, e); n_fail++;
    end
    #2 rst_n = 1'b0;
    #1;
    e = '0; n_checks++;
    if (obs !== e) begin
      $display("FAIL mid_async obs=%h exp=%h", obs, e); n_fail++;
    end
    req = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
    req = 2'b01;
    tick();
    e = pk(2'b00, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0); n_checks++;
    if (obs !== e) begin
      $display("FAIL mid_denied obs=%h exp=%h", obs, e); n_fail++;
    end
    tick();
    e = '0; n_checks++;
    if (obs !== e) begin
      $display("FAIL mid_no_grant obs=%h exp=%h", obs, e); n_fail++;
    end
    req = 2'b00;
    tick();
  endtask

  initial begin
    test_reset();
    test_grant();
    test_deny();
    test_round_robin();
    test_hold();
    test_independent();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
